contrast_gain_ctrl: RTL and testbench

//  Run-time controller for the contrast multiply/divide-by-4 pixel datapath. Turns

---
 rtl/contrast_pkg.sv | 20 ++
 rtl/key_debounce.sv | 56 +++++
 rtl/contrast_gain_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_contrast_gain_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/contrast_pkg.sv
// ---------------------------------------------------------------------------
// contrast_pkg
// Shared constants and types for the contrast gain controller.
//   GAIN_W / GAIN_MAX / GAIN_MIN / GAIN_UNITY : 3-bit gain range, 4 = unity
//   ctrl_state_t                              : MANUAL / AUTO_UP / AUTO_DN
// ---------------------------------------------------------------------------
package contrast_pkg;

    localparam int                GAIN_W     = 3;
    localparam logic [GAIN_W-1:0] GAIN_MAX   = 3'd7;
    localparam logic [GAIN_W-1:0] GAIN_MIN   = 3'd0;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 3'd4;

    typedef enum logic [1:0] {
        MANUAL  = 2'd0,
        AUTO_UP = 2'd1,
        AUTO_DN = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises one raw active-low push-key into clk, debounces it and emits a
// single-cycle pulse when a press (released -> pressed) is accepted.
// Ports:
//   clk      in  pixel clock
//   rst_n    in  asynchronous reset, active-low
//   i_key_n  in  raw asynchronous key level, 0 = pressed
//   o_press  out 1-cycle pulse on an accepted press; no auto-repeat
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int             CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;   // accepted (debounced) level, 1 = released
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_meta  <= i_key_n;
            r_sync  <= r_meta;
            r_press <= 1'b0;
            // The counter only runs while the synchronised level disagrees with
            // the accepted one; any return to the accepted level restarts it.
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync;
                r_press <= ~r_sync;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/contrast_gain_ctrl.sv
// ---------------------------------------------------------------------------
// contrast_gain_ctrl
// Run-time gain controller for the contrast datapath. Three debounced keys
// drive a manual gain (0..7) or a ping-pong auto sweep; the requested gain is
// committed to the datapath only at frame start. vs/hs/de are delayed to match
// the datapath latency.
// Ports:
//   clk, rst_n                     pixel clock, async active-low reset
//   key_up_n, key_dn_n, key_mode_n raw active-low keys (+1, -1, mode toggle)
//   vs_in, hs_in, de_in            video syncs; vs rising edge = frame start
//   mul_value                      committed gain to the datapath
//   vs_out, hs_out, de_out         syncs delayed DATA_LAT cycles
//   auto_mode                      1 while sweeping (AUTO_UP / AUTO_DN)
//   gain_dirty                     requested gain differs from committed gain
// ---------------------------------------------------------------------------
module contrast_gain_ctrl
    import contrast_pkg::*;
#(
    parameter int                DEBOUNCE_CYC = 1_000_000,
    parameter int                SWEEP_FRAMES = 60,
    parameter logic [GAIN_W-1:0] GAIN_RESET   = GAIN_UNITY,
    parameter int                DATA_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_up_n,
    input  logic              key_dn_n,
    input  logic              key_mode_n,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    output logic [GAIN_W-1:0] mul_value,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic              auto_mode,
    output logic              gain_dirty
);

    localparam int              FC_W    = (SWEEP_FRAMES > 1) ? $clog2(SWEEP_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(SWEEP_FRAMES - 1);

    function automatic logic [GAIN_W-1:0] sat_inc(input logic [GAIN_W-1:0] g);
        return (g == GAIN_MAX) ? g : g + GAIN_W'(1);
    endfunction

    function automatic logic [GAIN_W-1:0] sat_dec(input logic [GAIN_W-1:0] g);
        return (g == GAIN_MIN) ? g : g - GAIN_W'(1);
    endfunction

    logic              w_up_p;
    logic              w_dn_p;
    logic              w_mode_p;
    logic              w_frame_start;

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    logic [GAIN_W-1:0] r_gain_req;
    logic [GAIN_W-1:0] w_gain_nxt;
    logic [GAIN_W-1:0] w_gain_step;
    logic [FC_W-1:0]   r_frame_cnt;
    logic [FC_W-1:0]   w_cnt_nxt;
    logic [GAIN_W-1:0] r_mul;
    logic              r_vs_q1;
    logic              r_vs_q2;
    logic [2:0]        r_sync_dly [DATA_LAT];

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key_n (key_up_n),
        .o_press (w_up_p)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_dn (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key_n (key_dn_n),
        .o_press (w_dn_p)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key_n (key_mode_n),
        .o_press (w_mode_p)
    );

    // Edge detect on a registered copy of vs, so frame_start is one cycle
    // after the vs rising edge.
    assign w_frame_start = r_vs_q1 & ~r_vs_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MANUAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain_req;
        w_cnt_nxt   = r_frame_cnt;
        w_gain_step = (r_state == AUTO_DN) ? sat_dec(r_gain_req) : sat_inc(r_gain_req);
        case (r_state)
            MANUAL: begin
                // Mode wins over up/down arriving in the same cycle.
                if (w_mode_p) begin
                    w_state_nxt = (r_gain_req == GAIN_MAX) ? AUTO_DN : AUTO_UP;
                    w_cnt_nxt   = '0;
                end else if (w_up_p && !w_dn_p) begin
                    w_gain_nxt = sat_inc(r_gain_req);
                end else if (w_dn_p && !w_up_p) begin
                    w_gain_nxt = sat_dec(r_gain_req);
                end
            end
            AUTO_UP, AUTO_DN: begin
                if (w_mode_p) begin
                    w_state_nxt = MANUAL;
                    w_cnt_nxt   = '0;
                end else if (w_frame_start) begin
                    if (r_frame_cnt == FC_LAST) begin
                        w_cnt_nxt  = '0;
                        w_gain_nxt = w_gain_step;
                        // Reverse direction on reaching an end stop.
                        if (r_state == AUTO_UP && w_gain_step == GAIN_MAX) begin
                            w_state_nxt = AUTO_DN;
                        end else if (r_state == AUTO_DN && w_gain_step == GAIN_MIN) begin
                            w_state_nxt = AUTO_UP;
                        end
                    end else begin
                        w_cnt_nxt = r_frame_cnt + FC_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = MANUAL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gain_req  <= GAIN_RESET;
            r_frame_cnt <= '0;
            r_mul       <= GAIN_RESET;
            r_vs_q1     <= 1'b0;
            r_vs_q2     <= 1'b0;
        end else begin
            r_gain_req  <= w_gain_nxt;
            r_frame_cnt <= w_cnt_nxt;
            r_vs_q1     <= vs_in;
            r_vs_q2     <= r_vs_q1;
            // Commits the request held before this edge; a change made in the
            // same cycle waits for the following frame.
            if (w_frame_start) begin
                r_mul <= r_gain_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DATA_LAT; i++) begin
                r_sync_dly[i] <= 3'b000;
            end
        end else begin
            r_sync_dly[0] <= {vs_in, hs_in, de_in};
            for (int i = 1; i < DATA_LAT; i++) begin
                r_sync_dly[i] <= r_sync_dly[i-1];
            end
        end
    end

    assign vs_out     = r_sync_dly[DATA_LAT-1][2];
    assign hs_out     = r_sync_dly[DATA_LAT-1][1];
    assign de_out     = r_sync_dly[DATA_LAT-1][0];
    assign mul_value  = r_mul;
    assign auto_mode  = (r_state != MANUAL);
    assign gain_dirty = (r_gain_req != r_mul);

endmodule

// File: tb/tb_contrast_gain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_contrast_gain_ctrl
// Self-checking bench for contrast_gain_ctrl with short debounce/sweep settings.
// A behavioural model tracks requested gain, committed gain, mode and frame
// count at the level of whole key presses and whole frames.
// ---------------------------------------------------------------------------
module tb_contrast_gain_ctrl;

    localparam int DEB = 8;
    localparam int SWP = 2;
    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_up_n, key_dn_n, key_mode_n;
    logic       vs_in, hs_in, de_in;
    logic [2:0] mul_value;
    logic       vs_out, hs_out, de_out, auto_mode, gain_dirty;

    int checks   = 0;
    int failures = 0;

    // model: state 0 = manual, 1 = sweeping up, 2 = sweeping down
    int m_req, m_mul, m_state, m_frames;

    contrast_gain_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .SWEEP_FRAMES (SWP),
        .GAIN_RESET   (3'd4),
        .DATA_LAT     (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_up_n   (key_up_n),
        .key_dn_n   (key_dn_n),
        .key_mode_n (key_mode_n),
        .vs_in      (vs_in),
        .hs_in      (hs_in),
        .de_in      (de_in),
        .mul_value  (mul_value),
        .vs_out     (vs_out),
        .hs_out     (hs_out),
        .de_out     (de_out),
        .auto_mode  (auto_mode),
        .gain_dirty (gain_dirty)
    );

    always #5 clk = ~clk;

    // Sync outputs must equal the inputs seen at the previous clock edge.
    logic [2:0] cap    = 3'b000;
    logic       cap_ok = 1'b0;
    always @(posedge clk) begin
        cap    = {vs_in, hs_in, de_in};
        cap_ok = rst_n;
    end
    always @(negedge clk) begin
        if (cap_ok && rst_n) begin
            checks++;
            if ({vs_out, hs_out, de_out} !== cap) begin
                failures++;
                $display("FAIL sync_delay: got %b expected %b at %0t", {vs_out, hs_out, de_out}, cap, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        hs_in = 1'($urandom_range(0, 1));
        de_in = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic model_reset();
        m_req = 4; m_mul = 4; m_state = 0; m_frames = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        model_reset();
        wait_cyc(2);
    endtask

    task automatic model_press(input bit up, input bit dn, input bit mode);
        if (mode) begin
            if (m_state == 0) m_state = (m_req == 7) ? 2 : 1;
            else              m_state = 0;
            m_frames = 0;
        end else if (m_state == 0) begin
            if (up && !dn && m_req < 7) m_req++;
            if (dn && !up && m_req > 0) m_req--;
        end
    endtask

    task automatic model_frame();
        m_mul = m_req;
        if (m_state != 0) begin
            m_frames++;
            if (m_frames == SWP) begin
                m_frames = 0;
                if (m_state == 1) begin
                    m_req++;
                    if (m_req == 7) m_state = 2;
                end else begin
                    m_req--;
                    if (m_req == 0) m_state = 1;
                end
            end
        end
    endtask

    // Clean press: held well past the debounce time, then released.
    task automatic press(input bit up, input bit dn, input bit mode);
        key_up_n = ~up; key_dn_n = ~dn; key_mode_n = ~mode;
        wait_cyc(20);
        key_up_n = 1'b1; key_dn_n = 1'b1; key_mode_n = 1'b1;
        wait_cyc(20);
        model_press(up, dn, mode);
    endtask

    task automatic frame();
        vs_in = 1'b1;
        wait_cyc(4);
        vs_in = 1'b0;
        wait_cyc(4);
        model_frame();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cyc(2);
        @(negedge clk);
        checks++;
        if (mul_value !== 3'd4 || gain_dirty !== 1'b0 || auto_mode !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got mul=%0d dirty=%b auto=%b expected mul=4 dirty=0 auto=0", mul_value, gain_dirty, auto_mode);
        end
        checks++;
        if ({vs_out, hs_out, de_out} !== 3'b000) begin
            failures++;
            $display("FAIL reset_sync: got %b expected 000", {vs_out, hs_out, de_out});
        end
        rst_n = 1'b1;
        model_reset();
        wait_cyc(2);
    endtask

    task automatic test_manual_commit();
        apply_reset();
        repeat (3) press(1, 0, 0);
        @(negedge clk);
        checks++;
        if (mul_value !== 3'd4 || gain_dirty !== 1'b1) begin
            failures++;
            $display("FAIL pending_gain: got mul=%0d dirty=%b expected mul=4 dirty=1", mul_value, gain_dirty);
        end
        frame();
        @(negedge clk);
        checks++;
        if (mul_value !== 3'd7 || gain_dirty !== 1'b0) begin
            failures++;
            $display("FAIL commit_gain: got mul=%0d dirty=%b expected mul=7 dirty=0", mul_value, gain_dirty);
        end
    endtask

    task automatic test_bounce();
        int n;
        apply_reset();
        n = $urandom_range(4, 8);
        repeat (n) begin
            key_up_n = 1'b0;
            wait_cyc(3);
            key_up_n = 1'b1;
            wait_cyc($urandom_range(2, 5));
        end
        wait_cyc(20);
        @(negedge clk);
        checks++;
        if (gain_dirty !== 1'b0 || mul_value !== 3'd4) begin
            failures++;
            $display("FAIL bounce_ignored: got mul=%0d dirty=%b expected mul=4 dirty=0", mul_value, gain_dirty);
        end
        key_up_n = 1'b0;
        wait_cyc(20);
        key_up_n = 1'b1;
        wait_cyc(20);
        model_press(1, 0, 0);
        frame();
        @(negedge clk);
        checks++;
        if (mul_value !== 3'd5 || mul_value !== 3'(m_mul)) begin
            failures++;
            $display("FAIL long_press_one_step: got mul=%0d expected %0d", mul_value, m_mul);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        repeat (5) press(0, 1, 0);
        frame();
        @(negedge clk);
        checks++;
        if (mul_value !== 3'd0 || gain_dirty !== 1'b0) begin
            failures++;
            $display("FAIL sat_low: got mul=%0d dirty=%b expected mul=0 dirty=0", mul_value, gain_dirty);
        end
        press(1, 1, 0);
        frame();
        @(negedge clk);
        checks++;
        if (mul_value !== 3'd0 || gain_dirty !== 1'b0) begin
            failures++;
            $display("FAIL up_dn_same_cycle: got mul=%0d dirty=%b expected mul=0 dirty=0", mul_value, gain_dirty);
        end
    endtask

    task automatic test_auto_sweep();
        int exp_seq [7] = '{6, 6, 7, 7, 6, 6, 5};
        apply_reset();
        press(1, 0, 0);
        press(1, 0, 0);
        frame();
        press(0, 0, 1);
        @(negedge clk);
        checks++;
        if (auto_mode !== 1'b1) begin
            failures++;
            $display("FAIL enter_auto: got auto=%b expected 1", auto_mode);
        end
        for (int i = 0; i < 7; i++) begin
            frame();
            @(negedge clk);
            checks++;
            if (mul_value !== 3'(exp_seq[i]) || mul_value !== 3'(m_mul)) begin
                failures++;
                $display("FAIL sweep_step%0d: got mul=%0d expected %0d", i, mul_value, exp_seq[i]);
            end
        end
    endtask

    task automatic test_mode_up_held();
        int held_req;
        held_req = m_req;
        key_up_n = 1'b0;
        wait_cyc(20);
        press(0, 0, 1);
        key_up_n = 1'b1;
        wait_cyc(20);
        @(negedge clk);
        checks++;
        if (auto_mode !== 1'b0 || gain_dirty !== (m_req != m_mul) || m_req != held_req) begin
            failures++;
            $display("FAIL mode_exit: got auto=%b dirty=%b expected auto=0 dirty=%b", auto_mode, gain_dirty, (m_req != m_mul));
        end
        frame();
        @(negedge clk);
        checks++;
        if (mul_value !== 3'(held_req)) begin
            failures++;
            $display("FAIL mode_exit_req_kept: got mul=%0d expected %0d", mul_value, held_req);
        end
        // Re-entering auto must start counting frames from zero.
        press(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            frame();
            @(negedge clk);
            checks++;
            if (mul_value !== 3'(m_mul) || gain_dirty !== (m_req != m_mul)) begin
                failures++;
                $display("FAIL frame_cnt_cleared%0d: got mul=%0d dirty=%b expected mul=%0d dirty=%b", i, mul_value, gain_dirty, m_mul, (m_req != m_mul));
            end
        end
        press(0, 0, 1);
    endtask

    task automatic test_async_reset();
        apply_reset();
        press(1, 0, 0);
        frame();
        repeat (3) press(0, 1, 0);
        @(negedge clk);
        checks++;
        if (mul_value !== 3'd5 || gain_dirty !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_state: got mul=%0d dirty=%b expected mul=5 dirty=1", mul_value, gain_dirty);
        end
        vs_in = 1'b1;
        wait_cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mul_value !== 3'd4 || gain_dirty !== 1'b0 || {vs_out, hs_out, de_out} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset: got mul=%0d dirty=%b sync=%b expected mul=4 dirty=0 sync=000", mul_value, gain_dirty, {vs_out, hs_out, de_out});
        end
        vs_in = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        model_reset();
        wait_cyc(2);
    endtask

    task automatic test_random();
        int op;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: press(1, 0, 0);
                1: press(0, 1, 0);
                2: press(1, 1, 0);
                3: press(0, 0, 1);
                default: frame();
            endcase
            @(negedge clk);
            checks++;
            if (mul_value !== 3'(m_mul) || gain_dirty !== (m_req != m_mul) || auto_mode !== (m_state != 0)) begin
                failures++;
                $display("FAIL random_op%0d(%0d): got mul=%0d dirty=%b auto=%b expected mul=%0d dirty=%b auto=%b", i, op, mul_value, gain_dirty, auto_mode, m_mul, (m_req != m_mul), (m_state != 0));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key_up_n = 1'b1; key_dn_n = 1'b1; key_mode_n = 1'b1;
        vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
        model_reset();
        test_reset();
        test_manual_commit();
        test_bounce();
        test_saturation();
        test_auto_sweep();
        test_mode_up_held();
        test_async_reset();
        test_random();
        wait_cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
